// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - CPU request/response and data-memory port bundle of the load/store unit
interface load_store_unit_if #(parameter int addrW = 16);
  logic             reqValid;
  logic             reqReady;
  logic             reqWrite;
  logic [2:0]       funct3;
  logic [31:0]      byteAddr;
  logic [31:0]      storeData;
  logic             rspValid;
  logic [31:0]      loadData;
  logic             misaligned;
  logic [addrW-1:0] memAddr;
  logic [31:0]      memDataW;
  logic             memWE;
  logic [31:0]      memDataR;

  modport master (
    output reqValid, reqWrite, funct3, byteAddr, storeData, memDataR,
    input  reqReady, rspValid, loadData, misaligned, memAddr, memDataW, memWE
  );

  modport slave (
    input  reqValid, reqWrite, funct3, byteAddr, storeData, memDataR,
    output reqReady, rspValid, loadData, misaligned, memAddr, memDataW, memWE
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RISC-V byte load/store to word memory, sub-word stores as read-modify-write
module load_store_unit #(
  parameter int addrW = 16
) (
  input logic              sysCLK,
  input logic              resetN,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} state_t;

  state_t           state, state_nxt;
  logic             lat_write;
  logic [2:0]       lat_f3;
  logic [1:0]       lat_lane;
  logic [31:0]      lat_data;
  logic             lat_err;
  logic [addrW-1:0] mem_addr;
  logic [31:0]      mem_data_w;
  logic [31:0]      load_data;

  logic             accept;
  logic             f3_bad;
  logic             addr_bad;
  logic             req_err;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      ext;
  logic [31:0]      merged;
  logic             unused_bits;

  assign unused_bits = ^bus.byteAddr[31:addrW+2];
  assign accept      = (state == IDLE) && bus.reqValid;

  always_comb begin
    f3_bad = 1'b0;
    if (bus.reqWrite)
      f3_bad = !(bus.funct3 inside {3'b000, 3'b001, 3'b010});
    else
      f3_bad = bus.funct3 inside {3'b011, 3'b110, 3'b111};
    addr_bad = ((bus.funct3[1:0] == 2'b01) && bus.byteAddr[0]) ||
               ((bus.funct3 == 3'b010) && (bus.byteAddr[1:0] != 2'b00));
    req_err  = f3_bad || addr_bad;
  end

  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.reqValid) begin
        if (req_err)
          state_nxt = RESP;
        else if (bus.reqWrite && (bus.funct3 == 3'b010))
          state_nxt = WR;
        else
          state_nxt = RD;
      end
      RD:      state_nxt = DATA;
      DATA:    state_nxt = lat_write ? WR : RESP;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.reqReady   = resetN && (state == IDLE);
    bus.rspValid   = (state == RESP);
    bus.misaligned = (state == RESP) && lat_err;
    bus.memWE      = (state == WR);
    bus.memAddr    = mem_addr;
    bus.memDataW   = mem_data_w;
    bus.loadData   = load_data;
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from the word read in DATA.
  always_comb begin
    byte_sel = bus.memDataR[{lat_lane, 3'b000} +: 8];
    half_sel = lat_lane[1] ? bus.memDataR[31:16] : bus.memDataR[15:0];
    case (lat_f3)
      3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  ext = {24'h0, byte_sel};
      3'b001:  ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  ext = {16'h0, half_sel};
      default: ext = bus.memDataR;
    endcase
    merged = bus.memDataR;
    if (lat_f3 == 3'b000)
      merged[{lat_lane, 3'b000} +: 8] = lat_data[7:0];
    else if (lat_f3 == 3'b001) begin
      if (lat_lane[1])
        merged[31:16] = lat_data[15:0];
      else
        merged[15:0] = lat_data[15:0];
    end
  end

  always_ff @(posedge sysCLK or negedge resetN) begin
    if (!resetN) begin
      lat_write  <= 1'b0;
      lat_f3     <= 3'b000;
      lat_lane   <= 2'b00;
      lat_data   <= 32'h0;
      lat_err    <= 1'b0;
      mem_addr   <= '0;
      mem_data_w <= 32'h0;
      load_data  <= 32'h0;
    end else if (accept) begin
      lat_write  <= bus.reqWrite;
      lat_f3     <= bus.funct3;
      lat_lane   <= bus.byteAddr[1:0];
      lat_data   <= bus.storeData;
      lat_err    <= req_err;
      mem_addr   <= bus.byteAddr[addrW+1:2];
      mem_data_w <= bus.storeData;
      load_data  <= 32'h0;
    end else if (state == DATA) begin
      if (lat_write)
        mem_data_w <= merged;
      else
        load_data <= ext;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a word memory model
module tb_load_store_unit;

  localparam int AW = 16;

  logic sysCLK = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   fails  = 0;

  load_store_unit_if #(.addrW(AW)) bus();

  load_store_unit #(.addrW(AW)) dut (
    .sysCLK (sysCLK),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  always #5 sysCLK = ~sysCLK;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_addr;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;

  always @(posedge sysCLK) begin
    rd_addr <= bus.memAddr;
    if (bd_we)
      mem[bd_addr] <= bd_data;
    else if (bus.memWE)
      mem[bus.memAddr] <= bus.memDataW;
  end
  assign bus.memDataR = mem[rd_addr];

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge sysCLK);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge sysCLK);
    #1 bd_we = 1'b0;
  endtask

  // Issues one request and records per-cycle observations; cycle k=1 is the one after the accept edge.
  task automatic run_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, output int rsp_cycle, output int rsp_count,
                         output int we_count, output int we_first, output logic [31:0] ld,
                         output logic mis);
    int waitc = 0;
    rsp_cycle = 0; rsp_count = 0; we_count = 0; we_first = 0; ld = 'x; mis = 1'bx;
    @(negedge sysCLK);
    bus.reqValid = 1'b1; bus.reqWrite = wr; bus.funct3 = f3;
    bus.byteAddr = addr; bus.storeData = data;
    while (!bus.reqReady && waitc < 20) begin
      @(negedge sysCLK);
      waitc++;
    end
    if (!bus.reqReady) begin
      checks++; fails++;
      $display("FAIL accept_timeout: reqReady=%b required 1", bus.reqReady);
    end
    @(posedge sysCLK);
    #1 bus.reqValid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sysCLK);
      if (bus.rspValid) begin
        rsp_count++;
        if (rsp_cycle == 0) begin
          rsp_cycle = k; ld = bus.loadData; mis = bus.misaligned;
        end
      end
      if (bus.memWE) begin
        we_count++;
        if (we_first == 0) we_first = k;
      end
    end
  endtask

  task automatic test_reset();
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.funct3 = 3'b000;
    bus.byteAddr = 32'h0; bus.storeData = 32'h0;
    resetN = 1'b0;
    repeat (3) @(negedge sysCLK);
    checks++; if (bus.reqReady !== 1'b0) begin fails++; $display("FAIL reset_reqReady: got %b required 0", bus.reqReady); end
    checks++; if (bus.rspValid !== 1'b0) begin fails++; $display("FAIL reset_rspValid: got %b required 0", bus.rspValid); end
    checks++; if (bus.memWE !== 1'b0) begin fails++; $display("FAIL reset_memWE: got %b required 0", bus.memWE); end
    checks++; if (bus.memAddr !== 16'h0) begin fails++; $display("FAIL reset_memAddr: got %h required 0", bus.memAddr); end
    checks++; if (bus.memDataW !== 32'h0) begin fails++; $display("FAIL reset_memDataW: got %h required 0", bus.memDataW); end
    checks++; if (bus.loadData !== 32'h0) begin fails++; $display("FAIL reset_loadData: got %h required 0", bus.loadData); end
    checks++; if (bus.misaligned !== 1'b0) begin fails++; $display("FAIL reset_misaligned: got %b required 0", bus.misaligned); end
    resetN = 1'b1;
    @(negedge sysCLK);
    checks++; if (bus.reqReady !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b required 1", bus.reqReady); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [31:0] adrs [5] = '{32'h41, 32'h41, 32'h42, 32'h42, 32'h40};
    logic [31:0] exps [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
    int rc, rn, wc, wf; logic [31:0] ld; logic mis;
    preload(16'h10, 32'h8899AABB);
    for (int i = 0; i < 5; i++) begin
      run_req(1'b0, f3s[i], adrs[i], 32'h0, rc, rn, wc, wf, ld, mis);
      checks++; if (ld !== exps[i]) begin fails++; $display("FAIL load_data[%0d]: got %h required %h", i, ld, exps[i]); end
      checks++; if (mis !== 1'b0) begin fails++; $display("FAIL load_misaligned[%0d]: got %b required 0", i, mis); end
      checks++; if (rc != 3) begin fails++; $display("FAIL load_rsp_cycle[%0d]: got %0d required 3", i, rc); end
      checks++; if (rn != 1) begin fails++; $display("FAIL load_rsp_count[%0d]: got %0d required 1", i, rn); end
      checks++; if (wc != 0) begin fails++; $display("FAIL load_memWE[%0d]: got %0d cycles required 0", i, wc); end
    end
  endtask

  task automatic test_subword_store();
    int rc, rn, wc, wf; logic [31:0] ld; logic mis;
    run_req(1'b1, 3'b000, 32'h43, 32'h12345677, rc, rn, wc, wf, ld, mis);
    checks++; if (mem[16'h10] !== 32'h7799AABB) begin fails++; $display("FAIL sb_word: got %h required 7799aabb", mem[16'h10]); end
    checks++; if (wc != 1) begin fails++; $display("FAIL sb_we_count: got %0d required 1", wc); end
    checks++; if (wf != 3) begin fails++; $display("FAIL sb_we_cycle: got %0d required 3", wf); end
    checks++; if (rc != 4 || rn != 1) begin fails++; $display("FAIL sb_rsp: got cycle %0d count %0d required 4/1", rc, rn); end
    run_req(1'b1, 3'b001, 32'h40, 32'h0000CAFE, rc, rn, wc, wf, ld, mis);
    checks++; if (mem[16'h10] !== 32'h7799CAFE) begin fails++; $display("FAIL sh_word: got %h required 7799cafe", mem[16'h10]); end
    checks++; if (wc != 1) begin fails++; $display("FAIL sh_we_count: got %0d required 1", wc); end
    checks++; if (mis !== 1'b0) begin fails++; $display("FAIL sh_misaligned: got %b required 0", mis); end
  endtask

  task automatic test_word_store();
    int rc, rn, wc, wf; logic [31:0] ld; logic mis;
    run_req(1'b1, 3'b010, 32'h44, 32'hDEADBEEF, rc, rn, wc, wf, ld, mis);
    checks++; if (mem[16'h11] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_word: got %h required deadbeef", mem[16'h11]); end
    checks++; if (wf != 1 || wc != 1) begin fails++; $display("FAIL sw_we: got first %0d count %0d required 1/1", wf, wc); end
    checks++; if (rc != 2) begin fails++; $display("FAIL sw_rsp_cycle: got %0d required 2", rc); end
    checks++; if (mem[16'h10] !== 32'h7799CAFE) begin fails++; $display("FAIL sw_neighbour: got %h required 7799cafe", mem[16'h10]); end
  endtask

  task automatic test_errors();
    logic       wrs  [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0] f3s  [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] adrs[3] = '{32'h42, 32'h41, 32'h40};
    int rc, rn, wc, wf; logic [31:0] ld; logic mis;
    for (int i = 0; i < 3; i++) begin
      run_req(wrs[i], f3s[i], adrs[i], 32'hA5A5A5A5, rc, rn, wc, wf, ld, mis);
      checks++; if (mis !== 1'b1) begin fails++; $display("FAIL err_misaligned[%0d]: got %b required 1", i, mis); end
      checks++; if (ld !== 32'h0) begin fails++; $display("FAIL err_loadData[%0d]: got %h required 0", i, ld); end
      checks++; if (wc != 0) begin fails++; $display("FAIL err_memWE[%0d]: got %0d cycles required 0", i, wc); end
      checks++; if (rc != 1 || rn != 1) begin fails++; $display("FAIL err_rsp[%0d]: got cycle %0d count %0d required 1/1", i, rc, rn); end
      checks++; if (mem[16'h10] !== 32'h7799CAFE) begin fails++; $display("FAIL err_word[%0d]: got %h required 7799cafe", i, mem[16'h10]); end
    end
  endtask

  task automatic test_reset_midop();
    int we_seen = 0;
    int rsp_seen = 0;
    @(negedge sysCLK);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.funct3 = 3'b000;
    bus.byteAddr = 32'h40; bus.storeData = 32'h000000FF;
    @(posedge sysCLK);
    #1 bus.reqValid = 1'b0;
    @(posedge sysCLK);
    #2 resetN = 1'b0;
    #1;
    checks++; if (bus.memWE !== 1'b0) begin fails++; $display("FAIL midop_memWE_now: got %b required 0", bus.memWE); end
    checks++; if (bus.reqReady !== 1'b0) begin fails++; $display("FAIL midop_ready_in_reset: got %b required 0", bus.reqReady); end
    for (int k = 0; k < 3; k++) begin
      @(negedge sysCLK);
      if (bus.memWE) we_seen++;
      if (bus.rspValid) rsp_seen++;
    end
    resetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge sysCLK);
      if (bus.memWE) we_seen++;
      if (bus.rspValid) rsp_seen++;
    end
    checks++; if (we_seen != 0) begin fails++; $display("FAIL midop_memWE: got %0d cycles required 0", we_seen); end
    checks++; if (rsp_seen != 0) begin fails++; $display("FAIL midop_rspValid: got %0d cycles required 0", rsp_seen); end
    checks++; if (mem[16'h10] !== 32'h7799CAFE) begin fails++; $display("FAIL midop_word: got %h required 7799cafe", mem[16'h10]); end
    checks++; if (bus.reqReady !== 1'b1) begin fails++; $display("FAIL midop_ready: got %b required 1", bus.reqReady); end
  endtask

  task automatic test_back_to_back();
    int acc1 = -1;
    int acc2 = -1;
    logic rdy;
    logic [31:0] ld2 = 'x;
    @(negedge sysCLK);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.funct3 = 3'b010;
    bus.byteAddr = 32'h48; bus.storeData = 32'h01020304;
    for (int cyc = 0; cyc < 20; cyc++) begin
      rdy = bus.reqReady;
      @(posedge sysCLK);
      #1;
      if (rdy && bus.reqValid) begin
        if (acc1 < 0) begin
          acc1 = cyc;
          bus.reqWrite = 1'b0; bus.funct3 = 3'b100; bus.byteAddr = 32'h4A; bus.storeData = 32'h0;
        end else if (acc2 < 0) begin
          acc2 = cyc;
          bus.reqValid = 1'b0;
        end
      end
      @(negedge sysCLK);
      if (acc2 >= 0 && bus.rspValid) ld2 = bus.loadData;
    end
    bus.reqValid = 1'b0;
    checks++; if (acc1 < 0 || acc2 < 0) begin fails++; $display("FAIL b2b_accepts: got %0d/%0d required both accepted", acc1, acc2); end
    checks++; if (acc2 - acc1 != 3) begin fails++; $display("FAIL b2b_spacing: got %0d cycles required 3", acc2 - acc1); end
    checks++; if (mem[16'h12] !== 32'h01020304) begin fails++; $display("FAIL b2b_sw_word: got %h required 01020304", mem[16'h12]); end
    checks++; if (ld2 !== 32'h00000002) begin fails++; $display("FAIL b2b_lbu: got %h required 00000002", ld2); end
  endtask

  initial begin
    test_reset();
    test_load_ext();
    test_subword_store();
    test_word_store();
    test_errors();
    test_reset_midop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
